// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, state encoding and window packing for the 3x3 conv scheduler.
package conv_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int KERN_TAPS  = 9;
    typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, OUTPUT, DONE} state_e;
    // Tap index of window row r, column c; tap 0 is top-left, row-major.
    function automatic int win_idx(input int r, input int c);
        return r * 3 + c;
    endfunction
endpackage

// File: rtl/conv2d_frame_sched_if.sv
// conv2d_frame_sched_if: pixel stream, MAC window/kernel/handshake and result stream.
interface conv2d_frame_sched_if #(
    parameter int DATA_W = conv_pkg::DATA_W_DEF,
    parameter int ACC_W  = conv_pkg::ACC_W_DEF
);
    logic                                     pix_valid;
    logic                                     pix_ready;
    logic [DATA_W-1:0]                        pix_data;
    logic [conv_pkg::KERN_TAPS*DATA_W-1:0]    win_flat;
    logic [conv_pkg::KERN_TAPS*DATA_W-1:0]    kern_flat;
    logic                                     conv_start;
    logic                                     conv_done;
    logic [ACC_W-1:0]                         conv_out;
    logic                                     res_valid;
    logic                                     res_ready;
    logic [ACC_W-1:0]                         res_data;
    logic                                     res_last;
    modport master (
        input  pix_valid, pix_data, conv_done, conv_out, res_ready,
        output pix_ready, win_flat, kern_flat, conv_start, res_valid, res_data, res_last
    );
    modport slave (
        output pix_valid, pix_data, conv_done, conv_out, res_ready,
        input  pix_ready, win_flat, kern_flat, conv_start, res_valid, res_data, res_last
    );
endinterface

// File: rtl/line_buffer2.sv
// line_buffer2: two IMG_W-deep rows sharing one column address; a write pushes row 0 into row 1.
module line_buffer2 #(
    parameter int IMG_W  = 8,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rd0_o,
    output logic [DATA_W-1:0] rd1_o
);
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    always_ff @(posedge clk) begin
        if (we_i) begin
            lb1_q[addr_i] <= lb0_q[addr_i];
            lb0_q[addr_i] <= wdata_i;
        end
    end
    assign rd0_o = lb0_q[addr_i];
    assign rd1_o = lb1_q[addr_i];
endmodule

// File: rtl/conv2d_frame_sched.sv
// conv2d_frame_sched: streams a raster frame through line buffers and a 3x3 window,
// issuing one MAC per valid window position and returning results on a valid/ready stream.
module conv2d_frame_sched
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start_i,
    output logic              busy_o,
    output logic              frame_done_o,
    input  logic              k_we_i,
    input  logic [3:0]        k_addr_i,
    input  logic [DATA_W-1:0] k_data_i,
    conv2d_frame_sched_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    state_e            state_q, state_d;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [DATA_W-1:0] kern_q [KERN_TAPS];
    logic [DATA_W-1:0] win_q  [KERN_TAPS];
    logic [ACC_W-1:0]  res_data_q;
    logic              last_q;
    logic [DATA_W-1:0] lb0, lb1;
    logic              accept, col_end, at_window;
    assign accept    = state_q == ACCEPT && bus.pix_valid;
    assign col_end   = col_q == CW'(IMG_W - 1);
    assign at_window = row_q >= RW'(2) && col_q >= CW'(2);
    line_buffer2 #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (bus.pix_data),
        .rd0_o   (lb0),
        .rd1_o   (lb1)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            res_data_q <= '0;
            last_q     <= 1'b0;
            for (int i = 0; i < KERN_TAPS; i++) begin
                kern_q[i] <= '0;
                win_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            // Kernel is only writable between frames so a frame sees one coefficient set.
            if (state_q == IDLE && k_we_i && k_addr_i < 4'(KERN_TAPS))
                kern_q[k_addr_i] <= k_data_i;
            if (state_q == IDLE && frame_start_i) begin
                row_q <= '0;
                col_q <= '0;
            end
            if (accept) begin
                col_q  <= col_end ? '0 : col_q + 1'b1;
                row_q  <= col_end ? row_q + 1'b1 : row_q;
                last_q <= row_q == RW'(IMG_H - 1) && col_end;
                for (int r = 0; r < 3; r++) begin
                    win_q[win_idx(r, 0)] <= win_q[win_idx(r, 1)];
                    win_q[win_idx(r, 1)] <= win_q[win_idx(r, 2)];
                end
                win_q[win_idx(0, 2)] <= lb1;
                win_q[win_idx(1, 2)] <= lb0;
                win_q[win_idx(2, 2)] <= bus.pix_data;
            end
            if (state_q == WAIT && bus.conv_done)
                res_data_q <= bus.conv_out;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = frame_start_i ? ACCEPT : IDLE;
            ACCEPT:  state_d = accept && at_window ? ISSUE : ACCEPT;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = bus.conv_done ? OUTPUT : WAIT;
            OUTPUT:  state_d = bus.res_ready ? (last_q ? DONE : ACCEPT) : OUTPUT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign busy_o         = state_q != IDLE;
    assign frame_done_o   = state_q == DONE;
    assign bus.pix_ready  = state_q == ACCEPT;
    assign bus.conv_start = state_q == ISSUE;
    assign bus.res_valid  = state_q == OUTPUT;
    assign bus.res_last   = state_q == OUTPUT && last_q;
    assign bus.res_data   = res_data_q;
    for (genvar i = 0; i < KERN_TAPS; i++) begin : g_flat
        assign bus.win_flat[i*DATA_W +: DATA_W]  = win_q[i];
        assign bus.kern_flat[i*DATA_W +: DATA_W] = kern_q[i];
    end
endmodule

// File: tb/tb_conv2d_frame_sched.sv
// tb_conv2d_frame_sched: 4x4 frames against a behavioural 3x3 MAC with programmable latency;
// table-driven frames plus hand-written stall, busy-ignore and mid-frame reset sequences.
module tb_conv2d_frame_sched;
    localparam int W = 4, H = 4, DW = 8, AW = 16;
    typedef struct {
        logic [8:0][7:0]  kern;
        bit               ramp;
        int               lat;
        int               stall;
        int               inj;
        logic [3:0][15:0] exp;
    } vec_t;
    logic       clk = 0, rst_n = 1, frame_start = 0, k_we = 0;
    logic [3:0] k_addr = 0;
    logic [7:0] k_data = 0;
    logic       busy, frame_done;
    int         tests = 0, fails = 0;
    int         mac_lat = 1, mac_cnt;
    logic [15:0] mac_acc;
    vec_t       vecs [6];
    conv2d_frame_sched_if #(.DATA_W(DW), .ACC_W(AW)) bus ();
    conv2d_frame_sched #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .busy_o(busy),
        .frame_done_o(frame_done), .k_we_i(k_we), .k_addr_i(k_addr), .k_data_i(k_data), .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [15:0] mac_sum(input logic [71:0] w, input logic [71:0] k);
        logic [15:0] s;
        s = 0;
        for (int i = 0; i < 9; i++) s += {8'd0, w[i*8 +: 8]} * {8'd0, k[i*8 +: 8]};
        return s;
    endfunction
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mac_cnt <= 0;
            mac_acc <= 0;
        end else if (bus.conv_start) begin
            mac_cnt <= mac_lat;
            mac_acc <= mac_sum(bus.win_flat, bus.kern_flat);
        end else if (mac_cnt != 0) mac_cnt <= mac_cnt - 1;
    assign bus.conv_done = mac_cnt == 1;
    assign bus.conv_out  = mac_acc;
    function automatic logic [8:0][7:0] kern_fill(input logic [7:0] base, input logic [7:0] c4);
        logic [8:0][7:0] k;
        for (int i = 0; i < 9; i++) k[i] = base;
        k[4] = c4;
        return k;
    endfunction
    function automatic logic [3:0][15:0] exp4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction
    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic expire(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask
    task automatic write_kernel(input logic [8:0][7:0] k);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            k_we = 1; k_addr = 4'(i); k_data = k[i];
        end
        @(negedge clk);
        k_addr = 4'hf; k_data = 8'hff;
        @(negedge clk);
        k_we = 0;
        chk("kern_flat", bus.kern_flat, k);
    endtask
    task automatic start_frame();
        @(negedge clk);
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        chk("busy_after_start", busy, 1);
        chk("pix_ready_after_start", bus.pix_ready, 1);
    endtask
    task automatic feed(input bit ramp, input int n, input int inj);
        for (int p = 0; p < n; p++) begin
            int t;
            t = 0;
            bus.pix_valid = 1;
            bus.pix_data  = ramp ? 8'(p) : 8'd1;
            if (p == inj) begin
                frame_start = 1; k_we = 1; k_addr = 4; k_data = 5;
            end
            while (!bus.pix_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t == 100) begin
                expire("pix_ready_wait");
                break;
            end
            @(posedge clk);
            @(negedge clk);
            frame_start = 0;
            k_we = 0;
        end
        bus.pix_valid = 0;
    endtask
    task automatic collect(input logic [3:0][15:0] exp, input int stall);
        for (int n = 0; n < 4; n++) begin
            int t;
            t = 0;
            bus.res_ready = !(n == 0 && stall > 0);
            while (!bus.res_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t == 200) begin
                expire("res_valid_wait");
                return;
            end
            chk("res_data", bus.res_data, exp[n]);
            chk("res_last", bus.res_last, n == 3);
            if (n == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    chk("stall_res_valid", bus.res_valid, 1);
                    chk("stall_res_data", bus.res_data, exp[0]);
                    chk("stall_pix_ready", bus.pix_ready, 0);
                    chk("stall_conv_start", bus.conv_start, 0);
                end
                bus.res_ready = 1;
            end
            @(negedge clk);
        end
        chk("frame_done_pulse", frame_done, 1);
        chk("busy_in_done", busy, 1);
        @(negedge clk);
        chk("frame_done_clear", frame_done, 0);
        chk("busy_clear", busy, 0);
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_pix_ready"}, bus.pix_ready, 0);
        chk({tag, "_conv_start"}, bus.conv_start, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_last"}, bus.res_last, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
        chk({tag, "_kern_flat"}, bus.kern_flat, 0);
        chk({tag, "_win_flat"}, bus.win_flat, 0);
    endtask
    initial begin
        bus.pix_valid = 0;
        bus.pix_data  = 0;
        bus.res_ready = 0;
        vecs[0] = '{kern_fill(8'd1, 8'd1), 1'b0, 1, 0, -1, exp4(9, 9, 9, 9)};
        vecs[1] = '{kern_fill(8'd0, 8'd1), 1'b1, 3, 0, -1, exp4(5, 6, 9, 10)};
        vecs[2] = '{kern_fill(8'd2, 8'd2), 1'b1, 2, 0, -1, exp4(90, 108, 162, 180)};
        vecs[3] = '{kern_fill(8'd1, 8'd1), 1'b0, 1, 5, -1, exp4(9, 9, 9, 9)};
        vecs[4] = '{kern_fill(8'd1, 8'd1), 1'b0, 2, 0, 5, exp4(9, 9, 9, 9)};
        vecs[5] = '{kern_fill(8'd1, 8'd5), 1'b0, 1, 0, -1, exp4(13, 13, 13, 13)};
        #2 rst_n = 0;
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        for (int v = 0; v < 6; v++) begin
            mac_lat = vecs[v].lat;
            write_kernel(vecs[v].kern);
            start_frame();
            fork
                feed(vecs[v].ramp, 16, vecs[v].inj);
                collect(vecs[v].exp, vecs[v].stall);
            join
        end
        // Mid-frame reset after the 7th pixel, then a clean frame.
        mac_lat = 2;
        write_kernel(kern_fill(8'd1, 8'd1));
        start_frame();
        feed(1'b0, 7, -1);
        chk("pre_reset_busy", busy, 1);
        rst_n = 0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_reset_idle_ready", bus.pix_ready, 0);
        chk("post_reset_idle_busy", busy, 0);
        write_kernel(kern_fill(8'd1, 8'd1));
        start_frame();
        fork
            feed(1'b0, 16, -1);
            collect(exp4(9, 9, 9, 9), 0);
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
